// File: rtl/ppu_fb_writer_if.sv
// ppu_fb_writer_if: pixel-stream input and frame-buffer write/status bundle for ppu_fb_writer.
interface ppu_fb_writer_if;
    logic [1:0]  PX_OUT;
    logic        PX_valid;
    logic [1:0]  PPU_MODE;
    logic        FB_WR;
    logic [13:0] FB_ADDR;
    logic [7:0]  FB_DATA;
    logic        DISP_BANK;
    logic        FRAME_DONE;
    logic        LINE_OVF;
    modport master (
        output PX_OUT, PX_valid, PPU_MODE,
        input  FB_WR, FB_ADDR, FB_DATA, DISP_BANK, FRAME_DONE, LINE_OVF
    );
    modport slave (
        input  PX_OUT, PX_valid, PPU_MODE,
        output FB_WR, FB_ADDR, FB_DATA, DISP_BANK, FRAME_DONE, LINE_OVF
    );
endinterface

// File: rtl/ppu_fb_writer.sv
// ppu_fb_writer: packs 2-bit PPU pixels four per byte into a double-buffered frame buffer.
module ppu_fb_writer #(
    parameter int H_PIXELS       = 160,
    parameter int V_LINES        = 144,
    parameter int BYTES_PER_LINE = H_PIXELS / 4,
    parameter int BANK_SIZE      = BYTES_PER_LINE * V_LINES
) (
    input logic clk,
    input logic rst,
    ppu_fb_writer_if.slave bus
);
    typedef enum logic [1:0] {H_BLANK, V_BLANK, SCAN, DRAW} mode_t;
    localparam int XW = $clog2(H_PIXELS + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam int CW = $clog2(BYTES_PER_LINE + 1);
    localparam logic [XW-1:0] X_MAX    = XW'(H_PIXELS);
    localparam logic [YW-1:0] Y_MAX    = YW'(V_LINES);
    localparam logic [13:0]   LINE_INC = 14'(BYTES_PER_LINE);
    localparam logic [13:0]   BANK_OFF = 14'(BANK_SIZE);
    mode_t         mode, prev_mode;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] col;
    logic [13:0]   line_base, fb_addr, addr_n;
    logic [7:0]    shift, sh_n, fb_data, data_n;
    logic [1:0]    cnt;
    logic [2:0]    pend;
    logic          bank, fb_wr, frame_done, line_ovf;
    logic          eol, vbe, acc, ovf, full, flush, wr_n;
    assign mode = mode_t'(bus.PPU_MODE);
    always_comb begin
        eol    = prev_mode == DRAW && mode != DRAW;
        vbe    = prev_mode != V_BLANK && mode == V_BLANK;
        acc    = bus.PX_valid && y < Y_MAX && x < X_MAX;
        ovf    = bus.PX_valid && y < Y_MAX && x >= X_MAX;
        sh_n   = acc ? {shift[5:0], bus.PX_OUT} : shift;
        pend   = {1'b0, cnt} + {2'b00, acc};
        full   = pend == 3'd4;
        flush  = (eol || vbe) && pend != 3'd0 && !full;
        wr_n   = full || flush;
        // a partial group is left-aligned: the first pixel always lands in [7:6]
        data_n = full ? sh_n : 8'(sh_n << (4'd8 - {pend, 1'b0}));
        addr_n = (bank ? BANK_OFF : 14'd0) + line_base + 14'(col);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_mode  <= H_BLANK;
            bank       <= 1'b0;
            x          <= '0;
            y          <= '0;
            col        <= '0;
            line_base  <= '0;
            shift      <= '0;
            cnt        <= '0;
            fb_wr      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            frame_done <= 1'b0;
            line_ovf   <= 1'b0;
        end else begin
            prev_mode  <= mode;
            fb_wr      <= wr_n;
            frame_done <= vbe;
            line_ovf   <= !vbe && (line_ovf || ovf);
            bank       <= bank ^ vbe;
            if (wr_n) begin
                fb_addr <= addr_n;
                fb_data <= data_n;
            end
            if (eol || vbe) begin
                x     <= '0;
                col   <= '0;
                cnt   <= '0;
                shift <= '0;
            end else if (acc) begin
                x     <= x + 1'b1;
                cnt   <= cnt + 2'd1;
                shift <= sh_n;
                if (full) col <= col + 1'b1;
            end
            if (vbe) begin
                y         <= '0;
                line_base <= '0;
            end else if (eol && y < Y_MAX) begin
                y         <= y + 1'b1;
                line_base <= line_base + LINE_INC;
            end
        end
    end
    assign bus.FB_WR      = fb_wr;
    assign bus.FB_ADDR    = fb_addr;
    assign bus.FB_DATA    = fb_data;
    assign bus.DISP_BANK  = ~bank;
    assign bus.FRAME_DONE = frame_done;
    assign bus.LINE_OVF   = line_ovf;
endmodule

// File: tb/tb_ppu_fb_writer.sv
// tb_ppu_fb_writer: directed table-driven bench for ppu_fb_writer with a write-capture monitor.
module tb_ppu_fb_writer;
    localparam logic [1:0] HB = 2'd0, VB = 2'd1, DR = 2'd3;
    typedef struct {
        int          n;
        logic [15:0] px;
        bit          same;
        int          nw;
        logic [7:0]  d0;
        logic [7:0]  d1;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0, bad = 0, fd_cnt = 0, fd0 = 0, ey = 0, err = 0;
    logic [13:0] wa[$];
    logic [7:0]  wd[$];
    vec_t tbl[6];
    always #5 clk = ~clk;
    ppu_fb_writer_if bus();
    ppu_fb_writer dut (.clk(clk), .rst(rst), .bus(bus));
    always @(negedge clk) begin
        if (bus.FB_WR === 1'b1) begin
            wa.push_back(bus.FB_ADDR);
            wd.push_back(bus.FB_DATA);
        end
        if (bus.FRAME_DONE === 1'b1) fd_cnt++;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask
    task automatic step(input logic v, input logic [1:0] p, input logic [1:0] m);
        bus.PX_valid = v;
        bus.PX_OUT   = p;
        bus.PPU_MODE = m;
        @(posedge clk);
        #1;
    endtask
    task automatic px_line(input int n, input int kind);
        for (int i = 0; i < n; i++) step(1'b1, kind == 4 ? 2'(i % 4) : 2'(kind), DR);
        step(1'b0, 2'd0, HB);
    endtask
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr"}, bus.FB_WR, 0);
        chk({tag, "_addr"}, bus.FB_ADDR, 0);
        chk({tag, "_data"}, bus.FB_DATA, 0);
        chk({tag, "_fdone"}, bus.FRAME_DONE, 0);
        chk({tag, "_ovf"}, bus.LINE_OVF, 0);
        chk({tag, "_disp"}, bus.DISP_BANK, 1);
    endtask
    initial begin
        tbl[0] = '{6, 16'hFF90, 1'b0, 2, 8'hFF, 8'h90};
        tbl[1] = '{1, 16'h8000, 1'b0, 1, 8'h80, 8'h00};
        tbl[2] = '{3, 16'h6C00, 1'b0, 1, 8'h6C, 8'h00};
        tbl[3] = '{4, 16'h1B00, 1'b1, 1, 8'h1B, 8'h00};
        tbl[4] = '{7, 16'h55C8, 1'b1, 2, 8'h55, 8'hC8};
        tbl[5] = '{0, 16'h0000, 1'b0, 0, 8'h00, 8'h00};
        bus.PX_valid = 1'b0;
        bus.PX_OUT   = 2'd0;
        bus.PPU_MODE = HB;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 2'd0, HB);
        rst = 1'b0;
        chk_reset_outputs("rst");
        // full line of 0,1,2,3 pixels
        wa.delete(); wd.delete();
        px_line(160, 4);
        repeat (2) step(1'b0, 2'd0, HB);
        chk("l0_nwr", wa.size(), 40);
        for (int k = 0; k < wa.size() && k < 40; k++) begin
            chk($sformatf("l0_addr%0d", k), wa[k], k);
            chk($sformatf("l0_data%0d", k), wd[k], 8'h1B);
        end
        ey = 1;
        foreach (tbl[e]) begin
            wa.delete(); wd.delete();
            step(1'b0, 2'd0, DR);
            for (int i = 0; i < tbl[e].n; i++)
                step(1'b1, 2'(tbl[e].px >> (14 - 2 * i)), (tbl[e].same && i == tbl[e].n - 1) ? HB : DR);
            if (!tbl[e].same) step(1'b0, 2'd0, HB);
            repeat (2) step(1'b0, 2'd0, HB);
            chk($sformatf("t%0d_nwr", e), wa.size(), tbl[e].nw);
            if (tbl[e].nw > 0 && wa.size() > 0) begin
                chk($sformatf("t%0d_a0", e), wa[0], ey * 40);
                chk($sformatf("t%0d_d0", e), wd[0], tbl[e].d0);
            end
            if (tbl[e].nw > 1 && wa.size() > 1) begin
                chk($sformatf("t%0d_a1", e), wa[1], ey * 40 + 1);
                chk($sformatf("t%0d_d1", e), wd[1], tbl[e].d1);
            end
            ey++;
        end
        // overlong line: extra pixels dropped, sticky overflow until V_BLANK
        wa.delete(); wd.delete();
        px_line(162, 2);
        repeat (2) step(1'b0, 2'd0, HB);
        chk("ovf_nwr", wa.size(), 40);
        if (wa.size() > 0) begin
            chk("ovf_last_addr", wa[wa.size() - 1], ey * 40 + 39);
            chk("ovf_last_data", wd[wd.size() - 1], 8'hAA);
        end
        chk("ovf_set", bus.LINE_OVF, 1);
        ey++;
        wa.delete(); wd.delete();
        px_line(4, 0);
        repeat (2) step(1'b0, 2'd0, HB);
        chk("ovf_sticky", bus.LINE_OVF, 1);
        chk("ovf_next_nwr", wa.size(), 1);
        if (wa.size() > 0) chk("ovf_next_addr", wa[0], ey * 40);
        fd0 = fd_cnt;
        step(1'b0, 2'd0, VB);
        chk("vb_fdone", bus.FRAME_DONE, 1);
        chk("vb_ovf_clr", bus.LINE_OVF, 0);
        chk("vb_disp", bus.DISP_BANK, 0);
        repeat (3) step(1'b0, 2'd0, VB);
        chk("vb_fdone_low", bus.FRAME_DONE, 0);
        chk("vb_one_pulse", fd_cnt - fd0, 1);
        chk("vb_disp_hold", bus.DISP_BANK, 0);
        // reset in the middle of a group
        wa.delete(); wd.delete();
        step(1'b0, 2'd0, DR);
        step(1'b1, 2'd1, DR);
        step(1'b1, 2'd2, DR);
        rst = 1'b1;
        step(1'b1, 2'd3, DR);
        rst = 1'b0;
        chk_reset_outputs("mid");
        step(1'b0, 2'd0, HB);
        chk("mid_no_wr", wa.size(), 0);
        step(1'b1, 2'd3, DR);
        step(1'b1, 2'd2, DR);
        step(1'b1, 2'd1, DR);
        step(1'b1, 2'd0, DR);
        step(1'b0, 2'd0, HB);
        chk("mid_nwr", wa.size(), 1);
        if (wa.size() > 0) begin
            chk("mid_addr", wa[0], 0);
            chk("mid_data", wd[0], 8'hE4);
        end
        // complete frame into bank 0
        rst = 1'b1;
        step(1'b0, 2'd0, HB);
        rst = 1'b0;
        wa.delete(); wd.delete();
        fd0 = fd_cnt;
        for (int l = 0; l < 144; l++) px_line(160, 4);
        step(1'b0, 2'd0, HB);
        step(1'b0, 2'd0, VB);
        chk("fr_fdone", bus.FRAME_DONE, 1);
        chk("fr_disp", bus.DISP_BANK, 0);
        repeat (2) step(1'b0, 2'd0, VB);
        chk("fr_nwr", wa.size(), 5760);
        if (wa.size() > 0) chk("fr_last_addr", wa[wa.size() - 1], 5759);
        err = 0;
        for (int k = 0; k < wa.size(); k++) if (wa[k] !== 14'(k) || wd[k] !== 8'h1B) err++;
        chk("fr_seq_err", err, 0);
        chk("fr_one_pulse", fd_cnt - fd0, 1);
        // bank 1: first write offset, then 4th pixel coinciding with V_BLANK entry
        wa.delete(); wd.delete();
        fd0 = fd_cnt;
        step(1'b1, 2'd0, DR);
        step(1'b1, 2'd0, DR);
        step(1'b1, 2'd0, DR);
        step(1'b1, 2'd1, DR);
        chk("lat_wr", bus.FB_WR, 1);
        chk("lat_addr", bus.FB_ADDR, 5760);
        chk("lat_data", bus.FB_DATA, 8'h01);
        step(1'b1, 2'd3, DR);
        chk("wr_one_cycle", bus.FB_WR, 0);
        step(1'b1, 2'd3, DR);
        step(1'b1, 2'd3, DR);
        step(1'b1, 2'd3, VB);
        chk("co_wr", bus.FB_WR, 1);
        chk("co_fdone", bus.FRAME_DONE, 1);
        chk("co_disp", bus.DISP_BANK, 1);
        repeat (3) step(1'b0, 2'd0, VB);
        chk("co_nwr", wa.size(), 2);
        if (wa.size() > 1) begin
            chk("co_addr", wa[1], 5761);
            chk("co_data", wd[1], 8'hFF);
        end
        chk("co_one_pulse", fd_cnt - fd0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
